window_cost_select: RTL and testbench

Streaming sliding-window selector for the account/arbitration datapath. Each input beat carries an account ID and two operands A and T; its cost is A×T. Once the window holds WIN beats, every accepted beat produces one output: the account with the minimum cost (or maximum, per mode) among the last WIN beats. It generalises the fixed 5-deep, 8-bit, min-only selector to parametrised width and depth, adds selectable min/max mode, downstream backpressure and a synchronous flush. Single clock domain; the CDC wrapper sits outside this block.

---
 rtl/wcs_pkg.sv | 22 ++
 rtl/cost_select.sv | 44 ++++
 rtl/window_cost_select.sv | 131 +++++++++++++
 tb/tb_window_cost_select.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wcs_pkg.sv
// Shared definitions for the sliding-window cost selector: mode encoding,
// cost width helper and window-depth legality check.
package wcs_pkg;

    typedef enum logic {
        MODE_MIN = 1'b0,
        MODE_MAX = 1'b1
    } mode_e;

    localparam int WIN_MIN = 2;
    localparam int WIN_MAX = 16;

    // A cost is the full-width product of two DSIZE-bit operands.
    function automatic int cost_width(input int dsize);
        return 2 * dsize;
    endfunction

    function automatic bit win_legal(input int win);
        return (win >= WIN_MIN) && (win <= WIN_MAX);
    endfunction

endpackage

// File: rtl/cost_select.sv
// Combinational argmin/argmax over WIN {cost, account} pairs, index 0 newest.
// Ties resolve to the newest entry in both modes.
module cost_select
    import wcs_pkg::*;
#(
    parameter  int DSIZE = 8,
    parameter  int WIN   = 5,
    localparam int CW    = cost_width(DSIZE),
    localparam int IW    = $clog2(WIN)
) (
    input  logic             i_mode,
    input  logic [CW-1:0]    i_costs    [WIN],
    input  logic [DSIZE-1:0] i_accounts [WIN],
    output logic [IW-1:0]    o_idx,
    output logic [CW-1:0]    o_cost,
    output logic [DSIZE-1:0] o_account
);

    logic [CW-1:0]    w_best_cost [WIN];
    logic [DSIZE-1:0] w_best_acct [WIN];
    logic [IW-1:0]    w_best_idx  [WIN];

    assign w_best_cost[0] = i_costs[0];
    assign w_best_acct[0] = i_accounts[0];
    assign w_best_idx[0]  = '0;

    // Walk from newest to oldest; an older entry only wins if strictly better.
    genvar gi;
    generate
        for (gi = 1; gi < WIN; gi++) begin : g_stage
            logic w_better;
            assign w_better = (i_mode == MODE_MAX) ? (i_costs[gi] > w_best_cost[gi-1])
                                                   : (i_costs[gi] < w_best_cost[gi-1]);
            assign w_best_cost[gi] = w_better ? i_costs[gi]    : w_best_cost[gi-1];
            assign w_best_acct[gi] = w_better ? i_accounts[gi] : w_best_acct[gi-1];
            assign w_best_idx[gi]  = w_better ? IW'(gi)        : w_best_idx[gi-1];
        end
    endgenerate

    assign o_idx     = w_best_idx[WIN-1];
    assign o_cost    = w_best_cost[WIN-1];
    assign o_account = w_best_acct[WIN-1];

endmodule

// File: rtl/window_cost_select.sv
// Streaming sliding-window min/max cost selector: shift window, fill counter,
// alive flag and a single-entry output register with backpressure and flush.
module window_cost_select
    import wcs_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int WIN   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               mode,
    input  logic               in_valid,
    input  logic [DSIZE-1:0]   in_account,
    input  logic [DSIZE-1:0]   in_A,
    input  logic [DSIZE-1:0]   in_T,
    output logic               ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DSIZE-1:0]   out_account,
    output logic [2*DSIZE-1:0] out_cost
);

    localparam int CW = cost_width(DSIZE);
    localparam int FW = $clog2(WIN + 1);
    localparam int IW = $clog2(WIN);
    localparam logic [FW-1:0] FILL_FULL = FW'(WIN);
    localparam logic [FW-1:0] FILL_LAST = FW'(WIN - 1);

    generate
        if (!win_legal(WIN)) begin : g_bad_win
            $error("window_cost_select: WIN must lie in 2..16");
        end
    endgenerate

    logic             r_alive;
    logic [FW-1:0]    r_fill;
    logic             r_out_valid;
    logic [DSIZE-1:0] r_out_account;
    logic [CW-1:0]    r_out_cost;
    logic [CW-1:0]    r_win_cost [WIN];
    logic [DSIZE-1:0] r_win_acct [WIN];

    logic [CW-1:0]    w_cost_in;
    logic             w_accept;
    logic             w_gen;
    logic [CW-1:0]    w_cand_cost [WIN];
    logic [DSIZE-1:0] w_cand_acct [WIN];
    logic [IW-1:0]    w_sel_idx;
    logic [CW-1:0]    w_sel_cost;
    logic [DSIZE-1:0] w_sel_account;
    logic             w_unused_idx;

    assign w_cost_in = CW'(in_A) * CW'(in_T);

    // Filling beats never need the output slot, so only a generating beat waits on it.
    assign ready    = r_alive && !flush && ((r_fill < FILL_LAST) || !r_out_valid || out_ready);
    assign w_accept = in_valid && ready;
    assign w_gen    = w_accept && (r_fill >= FILL_LAST);

    // Candidate window is the window as it will look after this beat shifts in.
    genvar gi;
    generate
        for (gi = 0; gi < WIN; gi++) begin : g_cand
            if (gi == 0) begin : g_head
                assign w_cand_cost[gi] = w_cost_in;
                assign w_cand_acct[gi] = in_account;
            end else begin : g_tail
                assign w_cand_cost[gi] = r_win_cost[gi-1];
                assign w_cand_acct[gi] = r_win_acct[gi-1];
            end
        end
    endgenerate

    cost_select #(
        .DSIZE (DSIZE),
        .WIN   (WIN)
    ) u_cost_select (
        .i_mode     (mode),
        .i_costs    (w_cand_cost),
        .i_accounts (w_cand_acct),
        .o_idx      (w_sel_idx),
        .o_cost     (w_sel_cost),
        .o_account  (w_sel_account)
    );

    // The winning pair already carries everything downstream needs.
    assign w_unused_idx = ^w_sel_idx;

    // Window storage is deliberately unreset; r_fill alone decides validity.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < WIN; i++) begin
                r_win_cost[i] <= w_cand_cost[i];
                r_win_acct[i] <= w_cand_acct[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alive       <= 1'b0;
            r_fill        <= '0;
            r_out_valid   <= 1'b0;
            r_out_account <= '0;
            r_out_cost    <= '0;
        end else begin
            r_alive <= 1'b1;
            if (flush) begin
                r_fill      <= '0;
                r_out_valid <= 1'b0;
            end else begin
                if (w_accept && (r_fill != FILL_FULL)) begin
                    r_fill <= r_fill + FW'(1);
                end
                if (w_gen) begin
                    r_out_valid   <= 1'b1;
                    r_out_account <= w_sel_account;
                    r_out_cost    <= w_sel_cost;
                end else if (out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_account = r_out_account;
    assign out_cost    = r_out_cost;

endmodule

// File: tb/tb_window_cost_select.sv
// Bench for window_cost_select: directed table and hand sequences on an 8/5
// instance, plus random soak on 8/5 and 12/9 instances against a queue model.
`timescale 1ns/1ps
module tb_window_cost_select;

    localparam int D0 = 8;
    localparam int W0 = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Reference selection: last w beats of the history, ties to the newest.
    function automatic void pick(input int unsigned qc[$], input int unsigned qa[$], input int w,
                                 input bit m, output int unsigned oa, output int unsigned oc);
        int n = qc.size();
        int b = n - w;
        for (int i = n - w + 1; i < n; i++) begin
            if (m ? (qc[i] >= qc[b]) : (qc[i] <= qc[b])) b = i;
        end
        oa = qa[b];
        oc = qc[b];
    endfunction

    // Directed DUT
    logic          rst_n, flush, mode, in_valid, ready, out_valid, out_ready;
    logic [D0-1:0] in_account, in_A, in_T, out_account;
    logic [2*D0-1:0] out_cost;

    window_cost_select #(.DSIZE(D0), .WIN(W0)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .mode        (mode),
        .in_valid    (in_valid),
        .in_account  (in_account),
        .in_A        (in_A),
        .in_T        (in_T),
        .ready       (ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_account (out_account),
        .out_cost    (out_cost)
    );

    typedef struct {
        bit         rst;
        logic [7:0] acct;
        logic [7:0] a;
        logic [7:0] t;
        bit         m;
        bit         ev;
        logic [7:0] eacct;
        logic [15:0] ecost;
    } vec_t;

    vec_t tbl [17];

    // Drive one cycle: inputs after negedge, ready sampled before the edge,
    // returns #1 after the rising edge so outputs can be read.
    task automatic step(input bit v, input logic [7:0] acct, input logic [7:0] a, input logic [7:0] t,
                        input bit m, input bit ordy, input bit fl, output bit rdy);
        @(negedge clk);
        in_valid = v; in_account = acct; in_A = a; in_T = t;
        mode = m; out_ready = ordy; flush = fl;
        #1 rdy = ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; mode = 1'b0;
        #1;
        check("rst_ready", ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_account", out_account, 0);
        check("rst_out_cost", out_cost, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("ready_before_first_edge", ready, 0);
        @(posedge clk);
        #1 check("ready_after_first_edge", ready, 1);
    endtask

    initial begin
        bit rdy;
        int unsigned ea, ec;
        int unsigned mc[$], ma[$];
        logic [7:0] a, t;

        rst_n = 1'b0; flush = 1'b0; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_account = '0; in_A = '0; in_T = '0;

        //           rst  acct   A      T     m  ev  eacct  ecost
        tbl[0]  = '{1'b1, 8'd1,  8'd2,  8'd3, 0, 0, 8'd0,  16'd0};
        tbl[1]  = '{1'b0, 8'd2,  8'd1,  8'd4, 0, 0, 8'd0,  16'd0};
        tbl[2]  = '{1'b0, 8'd3,  8'd3,  8'd3, 0, 0, 8'd0,  16'd0};
        tbl[3]  = '{1'b0, 8'd4,  8'd2,  8'd2, 0, 0, 8'd0,  16'd0};
        tbl[4]  = '{1'b0, 8'd5,  8'd5,  8'd1, 0, 1, 8'd4,  16'd4};
        tbl[5]  = '{1'b0, 8'd6,  8'd0,  8'd7, 0, 1, 8'd6,  16'd0};
        tbl[6]  = '{1'b0, 8'd7,  8'd1,  8'd1, 1, 1, 8'd3,  16'd9};
        tbl[7]  = '{1'b0, 8'd8,  8'd3,  8'd3, 1, 1, 8'd8,  16'd9};
        tbl[8]  = '{1'b0, 8'd9,  8'd255, 8'd255, 1, 1, 8'd9, 16'd65025};
        tbl[9]  = '{1'b0, 8'd10, 8'd255, 8'd255, 0, 1, 8'd6, 16'd0};
        tbl[10] = '{1'b0, 8'd11, 8'd0,  8'd0, 0, 1, 8'd11, 16'd0};
        tbl[11] = '{1'b0, 8'd12, 8'd2,  8'd2, 1, 1, 8'd10, 16'd65025};
        tbl[12] = '{1'b1, 8'd1,  8'd2,  8'd3, 1, 0, 8'd0,  16'd0};
        tbl[13] = '{1'b0, 8'd2,  8'd1,  8'd4, 1, 0, 8'd0,  16'd0};
        tbl[14] = '{1'b0, 8'd3,  8'd3,  8'd3, 1, 0, 8'd0,  16'd0};
        tbl[15] = '{1'b0, 8'd4,  8'd2,  8'd2, 1, 0, 8'd0,  16'd0};
        tbl[16] = '{1'b0, 8'd5,  8'd5,  8'd1, 1, 1, 8'd3,  16'd9};

        for (int i = 0; i < 17; i++) begin
            if (tbl[i].rst) do_reset();
            step(1'b1, tbl[i].acct, tbl[i].a, tbl[i].t, tbl[i].m, 1'b1, 1'b0, rdy);
            check("tbl_ready", rdy, 1);
            check("tbl_out_valid", out_valid, tbl[i].ev);
            if (tbl[i].ev) begin
                check("tbl_out_account", out_account, tbl[i].eacct);
                check("tbl_out_cost", out_cost, tbl[i].ecost);
            end
            $display("vec %0d acct=%0d A=%0d T=%0d mode=%0d -> valid=%0d acct=%0d cost=%0d",
                     i, tbl[i].acct, tbl[i].a, tbl[i].t, tbl[i].m, out_valid, out_account, out_cost);
        end

        // Backpressure: stall a full window, then resume one output per cycle
        do_reset();
        for (int b = 0; b < 5; b++) begin
            a = 8'($urandom_range(1, 15));
            t = 8'($urandom_range(1, 15));
            step(1'b1, 8'(40 + b), a, t, 1'b0, 1'b0, 1'b0, rdy);
            check("bp_fill_ready", rdy, 1);
            mc.push_back(32'(a) * 32'(t));
            ma.push_back(32'(40 + b));
            $display("bp fill acct=%0d cost=%0d", 40 + b, 32'(a) * 32'(t));
        end
        pick(mc, ma, W0, 1'b0, ea, ec);
        check("bp_first_valid", out_valid, 1);
        check("bp_first_account", out_account, ea);
        check("bp_first_cost", out_cost, ec);
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 8'd99, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, rdy);
            check("bp_stall_ready", rdy, 0);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_account", out_account, ea);
            check("bp_hold_cost", out_cost, ec);
            $display("bp stall %0d ready=%0d acct=%0d cost=%0d", c, rdy, out_account, out_cost);
        end
        for (int k = 0; k < 4; k++) begin
            a = 8'($urandom_range(0, 15));
            t = 8'($urandom_range(0, 15));
            step(1'b1, 8'(50 + k), a, t, 1'(k % 2), 1'b1, 1'b0, rdy);
            check("bp_resume_ready", rdy, 1);
            mc.push_back(32'(a) * 32'(t));
            ma.push_back(32'(50 + k));
            pick(mc, ma, W0, 1'(k % 2), ea, ec);
            check("bp_resume_valid", out_valid, 1);
            check("bp_resume_account", out_account, ea);
            check("bp_resume_cost", out_cost, ec);
            $display("bp resume acct=%0d cost=%0d", out_account, out_cost);
        end
        step(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, rdy);
        check("bp_drain_valid", out_valid, 0);

        // Flush: pre-flush zero costs must not leak into the next window
        do_reset();
        for (int b = 0; b < 3; b++) begin
            step(1'b1, 8'(60 + b), 8'd0, 8'd9, 1'b0, 1'b1, 1'b0, rdy);
        end
        step(1'b1, 8'd63, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1, rdy);
        check("flush_ready", rdy, 0);
        check("flush_out_valid", out_valid, 0);
        begin
            logic [7:0] fa [5];
            logic [7:0] ft [5];
            fa = '{8'd2, 8'd4, 8'd7, 8'd5, 8'd2};
            ft = '{8'd5, 8'd5, 8'd1, 8'd6, 8'd4};
            for (int b = 0; b < 5; b++) begin
                step(1'b1, 8'(21 + b), fa[b], ft[b], 1'b0, 1'b1, 1'b0, rdy);
                check("post_flush_ready", rdy, 1);
                check("post_flush_valid", out_valid, (b == 4) ? 1 : 0);
                $display("post-flush beat %0d valid=%0d acct=%0d cost=%0d", b, out_valid, out_account, out_cost);
            end
        end
        check("post_flush_account", out_account, 23);
        check("post_flush_cost", out_cost, 7);
        step(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, rdy);
        check("flush_drops_pending", out_valid, 0);
        step(1'b1, 8'd70, 8'd1, 8'd1, 1'b0, 1'b1, 1'b0, rdy);
        check("flush_refill_no_output", out_valid, 0);

        for (int c = 0; c < 60000; c++) begin
            if (g_soak[0].done && g_soak[1].done) break;
            @(posedge clk);
        end
        check("soak_finished", {g_soak[1].done, g_soak[0].done}, 2'b11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Random soak on two configurations
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_soak
            localparam int D = (gi == 0) ? 8 : 12;
            localparam int W = (gi == 0) ? 5 : 9;

            logic           s_rst_n, s_flush, s_mode, s_in_valid, s_ready, s_out_valid, s_out_ready;
            logic [D-1:0]   s_acct, s_a, s_t, s_out_acct;
            logic [2*D-1:0] s_out_cost;
            bit             done = 1'b0;

            window_cost_select #(.DSIZE(D), .WIN(W)) u_soak (
                .clk         (clk),
                .rst_n       (s_rst_n),
                .flush       (s_flush),
                .mode        (s_mode),
                .in_valid    (s_in_valid),
                .in_account  (s_acct),
                .in_A        (s_a),
                .in_T        (s_t),
                .ready       (s_ready),
                .out_valid   (s_out_valid),
                .out_ready   (s_out_ready),
                .out_account (s_out_acct),
                .out_cost    (s_out_cost)
            );

            initial begin
                int unsigned hc[$], ha[$], ec[$], ea[$];
                int unsigned oa, oc;
                int n_acc;
                int n_out;
                n_acc = 0;
                n_out = 0;
                s_rst_n = 1'b0; s_flush = 1'b0; s_mode = 1'b0; s_in_valid = 1'b0;
                s_out_ready = 1'b0; s_acct = '0; s_a = '0; s_t = '0;
                repeat (3) @(negedge clk);
                s_rst_n = 1'b1;
                for (int cyc = 0; cyc < 30000 + 8 && (n_acc < 4000 || cyc < 30000); cyc++) begin
                    @(negedge clk);
                    if (n_acc < 4000 && cyc < 30000) begin
                        s_in_valid  = ($urandom_range(0, 3) != 0);
                        s_out_ready = ($urandom_range(0, 3) != 0);
                        s_mode      = 1'($urandom_range(0, 1));
                        s_acct      = D'($urandom);
                        s_a = ($urandom_range(0, 2) == 0) ? D'($urandom_range(0, 3)) : D'($urandom);
                        s_t = ($urandom_range(0, 2) == 0) ? D'($urandom_range(0, 3)) : D'($urandom);
                    end else begin
                        s_in_valid  = 1'b0;
                        s_out_ready = 1'b1;
                    end
                    #1;
                    if (s_out_valid && s_out_ready) begin
                        n_out++;
                        if (ea.size() == 0) begin
                            check("soak_unexpected_output", ea.size(), 1);
                        end else begin
                            oa = ea.pop_front();
                            oc = ec.pop_front();
                            check("soak_account", s_out_acct, oa);
                            check("soak_cost", s_out_cost, oc);
                            $display("soak%0d out %0d acct=%0d cost=%0d", gi, n_out, s_out_acct, s_out_cost);
                        end
                    end
                    if (s_in_valid && s_ready) begin
                        hc.push_back(32'(s_a) * 32'(s_t));
                        ha.push_back(32'(s_acct));
                        n_acc++;
                        if (hc.size() > W) begin
                            void'(hc.pop_front());
                            void'(ha.pop_front());
                        end
                        if (hc.size() == W) begin
                            pick(hc, ha, W, s_mode, oa, oc);
                            ea.push_back(oa);
                            ec.push_back(oc);
                        end
                    end
                    if (cyc >= 30000 && ea.size() == 0 && !s_out_valid) break;
                end
                check("soak_beats", n_acc, 4000);
                check("soak_output_count", n_out, n_acc - W + 1);
                check("soak_leftover", ea.size(), 0);
                done = 1'b1;
            end
        end
    endgenerate

endmodule
